exec_stage: RTL and testbench

- Execute stage of the 16-bit CPU; sits directly upstream of the 8x16 register file.
- Consumes decoded operands valA/valB, opcode and destination register from decode.
- Produces the register file write port: wben, rD, valE.
- Single-cycle ALU ops plus an optional iterative 16-cycle shift-add multiply; holds a condition-code register.

---
 rtl/exec_stage.sv | 169 ++++++++++++++++
 tb/tb_exec_stage.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU feeding the register file write port, plus condition codes.
// Define EXEC_MUL_EN for the iterative shift-add multiply on op 111; otherwise op 111 is MOV.
module exec_stage #(
  parameter int DATA_W = 16,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valB,
  input  logic [AW-1:0]     dst,
  input  logic              wr_req,
  input  logic              set_cc,
  output logic              wben,
  output logic [AW-1:0]     rD,
  output logic [DATA_W-1:0] valE,
  output logic [3:0]        cc,
  output logic              busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_X7  = 3'b111;

  logic [DATA_W-1:0] w_res;
  logic [DATA_W:0]   w_wide;
  logic              w_c;
  logic              w_v;
  logic              w_accept;

  // The extra bit of w_wide catches carry/borrow, or the last bit shifted out.
  always_comb begin
    w_res  = '0;
    w_wide = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    case (op)
      OP_ADD: begin
        w_wide = {1'b0, valA} + {1'b0, valB};
        w_res  = w_wide[DATA_W-1:0];
        w_c    = w_wide[DATA_W];
        w_v    = (valA[DATA_W-1] == valB[DATA_W-1]) && (w_res[DATA_W-1] != valA[DATA_W-1]);
      end
      OP_SUB: begin
        w_wide = {1'b0, valA} - {1'b0, valB};
        w_res  = w_wide[DATA_W-1:0];
        w_c    = w_wide[DATA_W];
        w_v    = (valA[DATA_W-1] != valB[DATA_W-1]) && (w_res[DATA_W-1] != valA[DATA_W-1]);
      end
      OP_AND: w_res = valA & valB;
      OP_OR:  w_res = valA | valB;
      OP_XOR: w_res = valA ^ valB;
      OP_SHL: begin
        w_wide = {1'b0, valA} << valB[3:0];
        w_res  = w_wide[DATA_W-1:0];
        w_c    = w_wide[DATA_W];
      end
      OP_SHR: begin
        w_wide = {valA, 1'b0} >> valB[3:0];
        w_res  = w_wide[DATA_W:1];
        w_c    = w_wide[0];
      end
      OP_X7:  w_res = valB;
    endcase
  end

  assign w_accept = in_valid && in_ready;

`ifdef EXEC_MUL_EN
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_MUL_DONE} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_acc;
  logic [DATA_W-1:0]   r_mA;
  logic [DATA_W-1:0]   r_mB;
  logic [AW-1:0]       r_mDst;
  logic                r_mWr;
  logic                r_mSetCc;
  logic                w_mHi;

  assign w_mHi    = |r_acc[2*DATA_W-1:DATA_W];
  assign in_ready = (r_state == S_IDLE) && !RESET;
  assign busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mA     <= '0;
      r_mB     <= '0;
      r_mDst   <= '0;
      r_mWr    <= 1'b0;
      r_mSetCc <= 1'b0;
      wben     <= 1'b0;
      rD       <= '0;
      valE     <= '0;
      cc       <= '0;
    end else begin
      wben <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && op == OP_X7) begin
            r_mA     <= valA;
            r_mB     <= valB;
            r_mDst   <= dst;
            r_mWr    <= wr_req;
            r_mSetCc <= set_cc;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_MUL_RUN;
          end else if (w_accept) begin
            valE <= w_res;
            rD   <= dst;
            wben <= wr_req;
            if (set_cc) cc <= {(w_res == '0), w_res[DATA_W-1], w_c, w_v};
          end
        end
        // One multiplier bit per cycle, LSB first.
        S_MUL_RUN: begin
          if (r_mB[r_cnt]) r_acc <= r_acc + ({{DATA_W{1'b0}}, r_mA} << r_cnt);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1)) r_state <= S_MUL_DONE;
        end
        S_MUL_DONE: begin
          valE    <= r_acc[DATA_W-1:0];
          rD      <= r_mDst;
          wben    <= r_mWr;
          if (r_mSetCc) cc <= {(r_acc[DATA_W-1:0] == '0), r_acc[DATA_W-1], w_mHi, w_mHi};
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`else
  assign in_ready = !RESET;
  assign busy     = 1'b0;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      wben <= 1'b0;
      rD   <= '0;
      valE <= '0;
      cc   <= '0;
    end else begin
      wben <= 1'b0;
      if (w_accept) begin
        valE <= w_res;
        rD   <= dst;
        wben <= wr_req;
        if (set_cc) cc <= {(w_res == '0), w_res[DATA_W-1], w_c, w_v};
      end
    end
  end
`endif

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed scenarios plus randomized ALU traffic against an
// arithmetic reference model. Covers the multiply path when EXEC_MUL_EN is defined, MOV otherwise.
module tb_exec_stage;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [2:0]  op = '0;
  logic [15:0] valA = '0;
  logic [15:0] valB = '0;
  logic [2:0]  dst = '0;
  logic        wrReq = 1'b0;
  logic        setCc = 1'b0;
  logic        wben;
  logic [2:0]  rD;
  logic [15:0] valE;
  logic [3:0]  cc;
  logic        busy;

  int checks = 0;
  int fails = 0;
  logic [3:0] expCc = '0;

  always #5 clk = ~clk;

  exec_stage #(.DATA_W(16), .AW(3)) dut (
    .clk(clk), .RESET(RESET), .in_valid(inValid), .in_ready(inReady),
    .op(op), .valA(valA), .valB(valB), .dst(dst), .wr_req(wrReq), .set_cc(setCc),
    .wben(wben), .rD(rD), .valE(valE), .cc(cc), .busy(busy)
  );

  // Reference model: returns {result[15:0], Z, N, C, V} from plain integer arithmetic.
  function automatic logic [19:0] model(input int o, input int a, input int b);
    int r, s, sa, sb, t;
    longint p;
    bit c, v;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    s  = b & 15;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    case (o)
      0: begin r = a + b; c = (r > 65535); t = sa + sb; v = (t > 32767 || t < -32768); end
      1: begin r = a - b; c = (a < b);     t = sa - sb; v = (t > 32767 || t < -32768); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = a << s; c = (s != 0) ? bit'((a >> (16 - s)) & 1) : 1'b0; end
      6: begin r = a >> s; c = (s != 0) ? bit'((a >> (s - 1)) & 1) : 1'b0; end
      default: begin
`ifdef EXEC_MUL_EN
        p = longint'(a) * longint'(b);
        r = int'(p & 64'd65535);
        c = (p > 64'd65535);
        v = c;
`else
        p = 0;
        r = b;
`endif
      end
    endcase
    r = r & 65535;
    return {r[15:0], (r == 0), r[15], c, v};
  endfunction

  // Presents one instruction for a single edge; caller is just after a rising edge with the stage idle.
  task automatic drive_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input logic wr, input logic sc);
    op = o; valA = a; valB = b; dst = d; wrReq = wr; setCc = sc; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (inReady !== 1'b0) begin fails++; $display("[TB] FAIL reset_in_ready_held: got %b expected 0", inReady); end
    @(negedge clk) RESET = 1'b0;
    @(posedge clk); #1;
    drive_op(3'b000, 16'h1234, 16'h8001, 3'd5, 1'b1, 1'b1);
    RESET = 1'b1;
    #1;
    checks++; if ({wben, rD, valE, cc, busy, inReady} !== 26'd0) begin
      fails++; $display("[TB] FAIL reset_async_outputs: got wben=%b rD=%0d valE=%h cc=%b busy=%b rdy=%b expected all 0",
                        wben, rD, valE, cc, busy, inReady);
    end
    @(negedge clk) RESET = 1'b0;
    #1;
    checks++; if (inReady !== 1'b1) begin fails++; $display("[TB] FAIL reset_release_ready: got %b expected 1", inReady); end
    @(posedge clk); #1;
    expCc = 4'b0000;
  endtask

  task automatic test_add();
    drive_op(3'b000, 16'h7FFF, 16'h0001, 3'd3, 1'b1, 1'b1);
    expCc = 4'b0101;
    checks++; if (wben !== 1'b1 || rD !== 3'd3) begin fails++; $display("[TB] FAIL add_write: got wben=%b rD=%0d expected 1/3", wben, rD); end
    checks++; if (valE !== 16'h8000) begin fails++; $display("[TB] FAIL add_valE: got %h expected 8000", valE); end
    checks++; if (cc !== expCc) begin fails++; $display("[TB] FAIL add_cc: got %b expected %b", cc, expCc); end
    @(posedge clk); #1;
    checks++; if (wben !== 1'b0) begin fails++; $display("[TB] FAIL add_wben_drop: got %b expected 0", wben); end
  endtask

  task automatic test_sub();
    drive_op(3'b001, 16'h0005, 16'h0005, 3'd2, 1'b0, 1'b1);
    expCc = 4'b1000;
    checks++; if (wben !== 1'b0) begin fails++; $display("[TB] FAIL sub_no_write: got wben=%b expected 0", wben); end
    checks++; if (cc !== expCc || valE !== 16'h0000 || rD !== 3'd2) begin
      fails++; $display("[TB] FAIL sub_equal: got cc=%b valE=%h rD=%0d expected %b/0000/2", cc, valE, rD, expCc);
    end
    drive_op(3'b001, 16'h0001, 16'h0002, 3'd4, 1'b1, 1'b1);
    expCc = 4'b0110;
    checks++; if (valE !== 16'hFFFF || cc !== expCc || wben !== 1'b1) begin
      fails++; $display("[TB] FAIL sub_borrow: got valE=%h cc=%b wben=%b expected FFFF/%b/1", valE, cc, wben, expCc);
    end
    drive_op(3'b010, 16'h0F0F, 16'hF0F0, 3'd1, 1'b1, 1'b0);
    checks++; if (valE !== 16'h0000 || cc !== expCc) begin
      fails++; $display("[TB] FAIL cc_hold: got valE=%h cc=%b expected 0000/%b", valE, cc, expCc);
    end
  endtask

  task automatic test_shift();
    drive_op(3'b101, 16'h8001, 16'h0001, 3'd6, 1'b1, 1'b1);
    expCc = 4'b0010;
    checks++; if (valE !== 16'h0002 || cc !== expCc) begin
      fails++; $display("[TB] FAIL shl_carry: got valE=%h cc=%b expected 0002/%b", valE, cc, expCc);
    end
    drive_op(3'b110, 16'h0003, 16'h0000, 3'd6, 1'b1, 1'b1);
    expCc = 4'b0000;
    checks++; if (valE !== 16'h0003 || cc !== expCc) begin
      fails++; $display("[TB] FAIL shr_zero_amount: got valE=%h cc=%b expected 0003/%b", valE, cc, expCc);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp;
    logic [2:0]  o;
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(0, 6));
      op = o; valA = 16'($urandom); valB = 16'($urandom); dst = 3'(i); wrReq = 1'b1; setCc = 1'b1;
      inValid = 1'b1;
      exp = model(int'(o), int'(valA), int'(valB));
      expCc = exp[3:0];
      @(posedge clk); #1;
      checks++; if (wben !== 1'b1 || valE !== exp[19:4] || rD !== 3'(i) || cc !== expCc) begin
        fails++; $display("[TB] FAIL b2b_%0d: got wben=%b valE=%h rD=%0d cc=%b expected 1/%h/%0d/%b",
                          i, wben, valE, rD, cc, exp[19:4], i, expCc);
      end
    end
    inValid = 1'b0;
    @(posedge clk); #1;
    checks++; if (wben !== 1'b0) begin fails++; $display("[TB] FAIL b2b_tail: got wben=%b expected 0", wben); end
  endtask

  task automatic test_random();
    logic [19:0] exp;
    logic [2:0]  o;
    logic [15:0] a, b, lastE;
    logic [2:0]  d;
    logic        wr, sc;
    for (int i = 0; i < 40; i++) begin
`ifdef EXEC_MUL_EN
      o = 3'($urandom_range(0, 6));
`else
      o = 3'($urandom_range(0, 7));
`endif
      a = 16'($urandom); b = 16'($urandom); d = 3'($urandom); wr = 1'($urandom); sc = 1'($urandom);
      if (i % 8 == 0) b = b & 16'hFFF0;
      drive_op(o, a, b, d, wr, sc);
      exp = model(int'(o), int'(a), int'(b));
      if (sc) expCc = exp[3:0];
      checks++; if (valE !== exp[19:4] || rD !== d || wben !== wr || cc !== expCc) begin
        fails++; $display("[TB] FAIL rand_%0d op=%0d a=%h b=%h: got valE=%h rD=%0d wben=%b cc=%b expected %h/%0d/%b/%b",
                          i, o, a, b, valE, rD, wben, cc, exp[19:4], d, wr, expCc);
      end
      if (i % 5 == 0) begin
        lastE = valE;
        op = 3'($urandom); valA = 16'($urandom); valB = 16'($urandom); setCc = 1'b1; wrReq = 1'b1;
        @(posedge clk); #1;
        checks++; if (wben !== 1'b0 || valE !== lastE || cc !== expCc) begin
          fails++; $display("[TB] FAIL idle_ignore_%0d: got wben=%b valE=%h cc=%b expected 0/%h/%b",
                            i, wben, valE, cc, lastE, expCc);
        end
      end
    end
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul();
    logic [19:0] exp;
    logic [15:0] a, b;
    logic [2:0]  d;
    int          lat;
    drive_op(3'b111, 16'h0100, 16'h0101, 3'd7, 1'b1, 1'b1);
    op = 3'b000; valA = 16'h0002; valB = 16'h0003; dst = 3'd1; wrReq = 1'b1; setCc = 1'b0; inValid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      checks++; if (inReady !== 1'b0 || busy !== 1'b1 || wben !== 1'b0) begin
        fails++; $display("[TB] FAIL mul_busy_cycle_%0d: got rdy=%b busy=%b wben=%b expected 0/1/0", k, inReady, busy, wben);
      end
      @(posedge clk); #1;
    end
    expCc = 4'b0011;
    checks++; if (wben !== 1'b1 || valE !== 16'h0100 || rD !== 3'd7 || cc !== expCc) begin
      fails++; $display("[TB] FAIL mul_result: got wben=%b valE=%h rD=%0d cc=%b expected 1/0100/7/%b", wben, valE, rD, cc, expCc);
    end
    checks++; if (inReady !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL mul_done_ready: got rdy=%b busy=%b expected 1/0", inReady, busy);
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    checks++; if (wben !== 1'b1 || valE !== 16'h0005 || rD !== 3'd1 || cc !== expCc) begin
      fails++; $display("[TB] FAIL mul_held_next: got wben=%b valE=%h rD=%0d cc=%b expected 1/0005/1/%b", wben, valE, rD, cc, expCc);
    end
    for (int i = 0; i < 4; i++) begin
      a = 16'($urandom); b = 16'($urandom); d = 3'($urandom);
      if (i == 0) b = 16'h0000;
      drive_op(3'b111, a, b, d, 1'b1, 1'b1);
      exp = model(7, int'(a), int'(b));
      expCc = exp[3:0];
      lat = 1;
      while (wben !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      checks++; if (lat != 17) begin fails++; $display("[TB] FAIL mul_latency_%0d: got %0d expected 17", i, lat); end
      checks++; if (valE !== exp[19:4] || rD !== d || cc !== expCc) begin
        fails++; $display("[TB] FAIL mul_rand_%0d a=%h b=%h: got valE=%h rD=%0d cc=%b expected %h/%0d/%b",
                          i, a, b, valE, rD, cc, exp[19:4], d, expCc);
      end
    end
  endtask

  task automatic test_mul_reset();
    bit sawWben;
    drive_op(3'b111, 16'h1234, 16'h00FF, 3'd2, 1'b1, 1'b1);
    repeat (7) begin @(posedge clk); #1; end
    RESET = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || inReady !== 1'b0 || cc !== 4'b0000 || wben !== 1'b0) begin
      fails++; $display("[TB] FAIL mul_abort: got busy=%b rdy=%b cc=%b wben=%b expected 0/0/0000/0", busy, inReady, cc, wben);
    end
    @(negedge clk) RESET = 1'b0;
    expCc = 4'b0000;
    sawWben = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (wben === 1'b1) sawWben = 1'b1; end
    checks++; if (sawWben || inReady !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL mul_abort_after: got wbenSeen=%b rdy=%b busy=%b expected 0/1/0", sawWben, inReady, busy);
    end
  endtask
`else
  task automatic test_mov();
    drive_op(3'b111, 16'h1234, 16'h0000, 3'd5, 1'b1, 1'b1);
    expCc = 4'b1000;
    checks++; if (wben !== 1'b1 || valE !== 16'h0000 || rD !== 3'd5 || cc !== expCc) begin
      fails++; $display("[TB] FAIL mov_zero: got wben=%b valE=%h rD=%0d cc=%b expected 1/0000/5/%b", wben, valE, rD, cc, expCc);
    end
    checks++; if (inReady !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL mov_single_cycle: got rdy=%b busy=%b expected 1/0", inReady, busy);
    end
    drive_op(3'b111, 16'hFFFF, 16'h8001, 3'd0, 1'b1, 1'b1);
    expCc = 4'b0100;
    checks++; if (valE !== 16'h8001 || cc !== expCc) begin
      fails++; $display("[TB] FAIL mov_neg: got valE=%h cc=%b expected 8001/%b", valE, cc, expCc);
    end
  endtask
`endif

  initial begin
    $display("[TB] exec_stage bench start");
    test_reset();
    test_add();
    test_sub();
    test_shift();
    test_back_to_back();
    test_random();
`ifdef EXEC_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mov();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
